mem_arbiter: RTL and testbench

- Shares the single-port byte-addressed `memory` RAM between two requesters: instruction fetch (port I, read-only) and load/store (port D, read/write).
- Performs round-robin arbitration, drives the RAM control signals from registers, and captures the read word.
- Returns one response per request over a valid/ready handshake.
- Sits between the CPU core and `memory`. The core never drives the RAM directly.

---
 rtl/mem_arb_pkg.sv | 23 ++
 rtl/mem_arbiter_rr_arb2.sv | 31 +++
 rtl/mem_arbiter.sv | 145 ++++++++++++++
 tb/tb_mem_arbiter.sv | 364 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arb_pkg
//  Brief    : Shared types and constants for the two-port memory arbiter
//  Revision : 1.0 - initial release
// ============================================================================
package mem_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    // Requester identifiers; also used as bit positions in the grant vector
    localparam logic PORT_I = 1'b0;
    localparam logic PORT_D = 1'b1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        ACCESS = 2'd1,
        RESP   = 2'd2
    } state_t;

endpackage
`default_nettype wire

// File: rtl/mem_arbiter_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module   : rr_arb2
//  Brief    : Two-requester round-robin grant (combinational, one-hot output).
//             The owner of last_grant loses a tie; the parent updates it.
//  Revision : 1.0 - initial release
// ============================================================================
module rr_arb2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    input  logic       enable,
    output logic [1:0] gnt
);

    // Single requester wins outright; on a tie the port not served last wins
    always_comb begin
        gnt = 2'b00;
        if (enable) begin
            case (req)
                2'b01:   gnt = 2'b01;
                2'b10:   gnt = 2'b10;
                2'b11:   gnt = (last_grant == PORT_I) ? 2'b10 : 2'b01;
                default: gnt = 2'b00;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : mem_arbiter
//  Brief    : Shares a single-port byte-addressed RAM between an instruction
//             fetch port (read-only) and a load/store port. One outstanding
//             transaction: IDLE -> ACCESS (1 cycle) -> RESP (until consumed).
//  Revision : 1.0 - initial release
// ============================================================================
module mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int NUM_OF_BYTES = 800
) (
    input  logic              clk,
    input  logic              rst_n,
    // fetch port
    input  logic              i_req_valid,
    output logic              i_req_ready,
    input  logic [ADDR_W-1:0] i_req_addr,
    output logic              i_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [DATA_W-1:0] i_rsp_rdata,
    output logic              i_rsp_err,
    // load/store port
    input  logic              d_req_valid,
    output logic              d_req_ready,
    input  logic              d_req_we,
    input  logic [ADDR_W-1:0] d_req_addr,
    input  logic [DATA_W-1:0] d_req_wdata,
    output logic              d_rsp_valid,
    input  logic              d_rsp_ready,
    output logic [DATA_W-1:0] d_rsp_rdata,
    output logic              d_rsp_err,
    // RAM side
    output logic [ADDR_W-1:0] mem_address,
    output logic              mem_read_en,
    output logic              mem_write_en,
    output logic [DATA_W-1:0] mem_write_data,
    input  logic [DATA_W-1:0] mem_read_data
);

    // Highest legal word address; compared unsigned so 0xFFFFFFFF never wraps in
    localparam logic [ADDR_W-1:0] C_MAX_ADDR = ADDR_W'(NUM_OF_BYTES - 4);

    state_t              r_state;
    state_t              w_state_next;
    logic                r_last_grant;
    logic                r_owner;
    logic                r_err;
    logic [DATA_W-1:0]   r_rsp_rdata;

    logic [1:0]          w_gnt;
    logic                w_arb_en;
    logic                w_hs;
    logic                w_sel_d;
    logic                w_we;
    logic                w_in_range;
    logic                w_rsp_ready;
    logic [ADDR_W-1:0]   w_addr;

    assign w_arb_en = (r_state == IDLE);

    rr_arb2 u_rr_arb2 (
        .req        ({d_req_valid, i_req_valid}),
        .last_grant (r_last_grant),
        .enable     (w_arb_en),
        .gnt        (w_gnt)
    );

    assign i_req_ready = w_gnt[0];
    assign d_req_ready = w_gnt[1];

    assign w_hs       = |w_gnt;
    assign w_sel_d    = w_gnt[1];
    assign w_addr     = w_sel_d ? d_req_addr : i_req_addr;
    assign w_we       = w_sel_d & d_req_we;
    assign w_in_range = (w_addr <= C_MAX_ADDR);

    assign w_rsp_ready = (r_owner == PORT_D) ? d_rsp_ready : i_rsp_ready;

    // Responses are steered to the owner only; the other port sees idle values
    assign i_rsp_valid = (r_state == RESP) && (r_owner == PORT_I);
    assign d_rsp_valid = (r_state == RESP) && (r_owner == PORT_D);
    assign i_rsp_err   = r_err && (r_owner == PORT_I);
    assign d_rsp_err   = r_err && (r_owner == PORT_D);
    assign i_rsp_rdata = (r_owner == PORT_I) ? r_rsp_rdata : '0;
    assign d_rsp_rdata = (r_owner == PORT_D) ? r_rsp_rdata : '0;

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state: handshake starts an access, access lasts one cycle, response waits for consumer
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            IDLE:    if (w_hs) w_state_next = ACCESS;
            ACCESS:  w_state_next = RESP;
            RESP:    if (w_rsp_ready) w_state_next = IDLE;
            default: w_state_next = IDLE;
        endcase
    end

    // Registered RAM controls, ownership and the captured response word
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            mem_address    <= '0;
            mem_read_en    <= 1'b0;
            mem_write_en   <= 1'b0;
            mem_write_data <= '0;
            r_rsp_rdata    <= '0;
            r_err          <= 1'b0;
            r_owner        <= PORT_I;
            r_last_grant   <= PORT_I;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_hs) begin
                        mem_address    <= w_addr;
                        mem_write_en   <= w_we & w_in_range;
                        mem_read_en    <= ~w_we & w_in_range;
                        mem_write_data <= w_sel_d ? d_req_wdata : '0;
                        r_err          <= ~w_in_range;
                        r_owner        <= w_sel_d ? PORT_D : PORT_I;
                        r_last_grant   <= w_sel_d ? PORT_D : PORT_I;
                    end
                end
                ACCESS: begin
                    // RAM drove read data at the mid-cycle negedge; writes commit at this edge
                    r_rsp_rdata  <= mem_read_en ? mem_read_data : '0;
                    mem_read_en  <= 1'b0;
                    mem_write_en <= 1'b0;
                end
                default: ;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mem_arbiter
//  Brief    : Self-checking bench for mem_arbiter with a byte-array RAM model
//             and a transaction-level reference model.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_arbiter;

    localparam int NB   = 800;
    localparam int MAXA = NB - 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        i_req_valid, i_req_ready, i_rsp_valid, i_rsp_ready, i_rsp_err;
    logic [31:0] i_req_addr, i_rsp_rdata;
    logic        d_req_valid, d_req_ready, d_req_we, d_rsp_valid, d_rsp_ready, d_rsp_err;
    logic [31:0] d_req_addr, d_req_wdata, d_rsp_rdata;
    logic [31:0] mem_address, mem_write_data, mem_read_data;
    logic        mem_read_en, mem_write_en;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    mem_arbiter #(.NUM_OF_BYTES(NB)) dut (
        .clk(clk), .rst_n(rst_n),
        .i_req_valid(i_req_valid), .i_req_ready(i_req_ready), .i_req_addr(i_req_addr),
        .i_rsp_valid(i_rsp_valid), .i_rsp_ready(i_rsp_ready), .i_rsp_rdata(i_rsp_rdata),
        .i_rsp_err(i_rsp_err),
        .d_req_valid(d_req_valid), .d_req_ready(d_req_ready), .d_req_we(d_req_we),
        .d_req_addr(d_req_addr), .d_req_wdata(d_req_wdata),
        .d_rsp_valid(d_rsp_valid), .d_rsp_ready(d_rsp_ready), .d_rsp_rdata(d_rsp_rdata),
        .d_rsp_err(d_rsp_err),
        .mem_address(mem_address), .mem_read_en(mem_read_en), .mem_write_en(mem_write_en),
        .mem_write_data(mem_write_data), .mem_read_data(mem_read_data)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
        n_cmp++;
        if (act !== expv) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, expv, $time);
        end
    endtask

    // ---------------- RAM stand-in: read at negedge, write at posedge ----------------
    logic [7:0] ram     [0:NB-1];
    logic [7:0] ref_mem [0:NB-1];
    int ra, wa;

    always @(negedge clk) begin
        if (mem_read_en && mem_address <= 32'(MAXA)) begin
            ra = int'(mem_address[15:0]);
            mem_read_data <= {ram[ra+3], ram[ra+2], ram[ra+1], ram[ra]};
        end else begin
            mem_read_data <= $urandom();
        end
    end

    always @(posedge clk) begin
        if (mem_write_en && mem_address <= 32'(MAXA)) begin
            wa = int'(mem_address[15:0]);
            for (int b = 0; b < 4; b++) ram[wa+b] <= mem_write_data[8*b +: 8];
        end
    end

    function automatic logic [31:0] ref_word(input int a);
        return {ref_mem[a+3], ref_mem[a+2], ref_mem[a+1], ref_mem[a]};
    endfunction

    // ---------------- transaction-level reference model ----------------
    // pend: a transaction is outstanding; hs: edge index at which it was accepted.
    bit          model_on = 0;
    bit          pend = 0;
    int          hs = 0;
    int          cyc = 0;
    bit          last = 0;            // 0 = I served last, 1 = D served last
    bit          t_port, t_we, t_err;
    logic [31:0] t_addr, t_wdata, t_rdata;
    bit          sch = 0, cons = 0;
    bit          s_port, s_we, s_err;
    logic [31:0] s_addr, s_wdata, s_rdata;
    bit          g_i, g_d;
    int          sa;
    bit          glog[$];
    int          gcyc[$];
    int          wr_pulses = 0, rd_pulses = 0;

    always @(posedge clk) begin
        cyc = cyc + 1;
        if (!rst_n) begin
            pend     = 0;
            last     = 0;
            model_on = 1;
        end else if (model_on) begin
            if (sch) begin
                pend = 1; hs = cyc;
                t_port = s_port; t_we = s_we; t_err = s_err;
                t_addr = s_addr; t_wdata = s_wdata; t_rdata = s_rdata;
                last = s_port;
            end else if (cons) begin
                pend = 0;
            end
        end
    end

    // Compare process: checks every cycle and decides what the next edge will do
    always @(negedge clk) begin
        sch  = 0;
        cons = 0;
        if (model_on) begin
            if (mem_write_en) wr_pulses++;
            if (mem_read_en)  rd_pulses++;
            if (d_req_valid && d_req_ready) begin glog.push_back(1'b1); gcyc.push_back(cyc); end
            if (i_req_valid && i_req_ready) begin glog.push_back(1'b0); gcyc.push_back(cyc); end
            if (!pend) begin
                g_d = d_req_valid && (!i_req_valid || last == 1'b0);
                g_i = i_req_valid && !g_d;
                chk("idle_i_req_ready", 32'(i_req_ready), 32'(g_i));
                chk("idle_d_req_ready", 32'(d_req_ready), 32'(g_d));
                chk("idle_rd_en", 32'(mem_read_en), 0);
                chk("idle_wr_en", 32'(mem_write_en), 0);
                chk("idle_i_rsp_valid", 32'(i_rsp_valid), 0);
                chk("idle_d_rsp_valid", 32'(d_rsp_valid), 0);
                if (rst_n && (g_i || g_d)) begin
                    sch     = 1;
                    s_port  = g_d;
                    s_we    = g_d && d_req_we;
                    s_addr  = g_d ? d_req_addr : i_req_addr;
                    s_wdata = d_req_wdata;
                    s_err   = (s_addr > 32'(MAXA));
                    s_rdata = 32'd0;
                    if (!s_err) begin
                        sa = int'(s_addr[15:0]);
                        if (s_we) for (int b = 0; b < 4; b++) ref_mem[sa+b] = s_wdata[8*b +: 8];
                        else      s_rdata = ref_word(sa);
                    end
                end
            end else if (cyc == hs) begin
                chk("acc_i_req_ready", 32'(i_req_ready), 0);
                chk("acc_d_req_ready", 32'(d_req_ready), 0);
                chk("acc_rd_en", 32'(mem_read_en), 32'(!t_we && !t_err));
                chk("acc_wr_en", 32'(mem_write_en), 32'(t_we && !t_err));
                chk("acc_addr", mem_address, t_addr);
                if (t_we) chk("acc_wdata", mem_write_data, t_wdata);
                chk("acc_i_rsp_valid", 32'(i_rsp_valid), 0);
                chk("acc_d_rsp_valid", 32'(d_rsp_valid), 0);
            end else begin
                chk("rsp_i_req_ready", 32'(i_req_ready), 0);
                chk("rsp_d_req_ready", 32'(d_req_ready), 0);
                chk("rsp_rd_en", 32'(mem_read_en), 0);
                chk("rsp_wr_en", 32'(mem_write_en), 0);
                chk("rsp_addr", mem_address, t_addr);
                chk("rsp_i_valid", 32'(i_rsp_valid), 32'(t_port == 1'b0));
                chk("rsp_d_valid", 32'(d_rsp_valid), 32'(t_port == 1'b1));
                if (t_port) begin
                    chk("rsp_d_rdata", d_rsp_rdata, t_rdata);
                    chk("rsp_d_err", 32'(d_rsp_err), 32'(t_err));
                    if (rst_n && d_rsp_ready) cons = 1;
                end else begin
                    chk("rsp_i_rdata", i_rsp_rdata, t_rdata);
                    chk("rsp_i_err", 32'(i_rsp_err), 32'(t_err));
                    if (rst_n && i_rsp_ready) cons = 1;
                end
            end
        end
    end

    // ---------------- directed transaction drivers ----------------
    task automatic d_txn(input bit we, input logic [31:0] addr, input logic [31:0] wdata,
                         output logic [31:0] rd, output logic er);
        int n;
        d_req_valid = 1; d_req_we = we; d_req_addr = addr; d_req_wdata = wdata; d_rsp_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_req_ready && n < 40);
        if (!d_req_ready) chk("d_req_timeout", 0, 1);
        @(posedge clk); #1;
        d_req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_rsp_valid && n < 40);
        if (!d_rsp_valid) chk("d_rsp_timeout", 0, 1);
        rd = d_rsp_rdata; er = d_rsp_err;
        @(posedge clk); #1;
    endtask

    task automatic i_txn(input logic [31:0] addr, output logic [31:0] rd, output logic er);
        int n;
        i_req_valid = 1; i_req_addr = addr; i_rsp_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_req_ready && n < 40);
        if (!i_req_ready) chk("i_req_timeout", 0, 1);
        @(posedge clk); #1;
        i_req_valid = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!i_rsp_valid && n < 40);
        if (!i_rsp_valid) chk("i_rsp_timeout", 0, 1);
        rd = i_rsp_rdata; er = i_rsp_err;
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] rnd_addr();
        int sel;
        sel = $urandom_range(0, 9);
        if (sel < 8) return 32'($urandom_range(0, MAXA));
        if (sel == 8) begin
            case ($urandom_range(0, 5))
                0: return 32'd796;
                1: return 32'd797;
                2: return 32'd799;
                3: return 32'd800;
                4: return 32'hFFFF_FFFC;
                default: return 32'hFFFF_FFFF;
            endcase
        end
        return $urandom();
    endfunction

    logic [31:0] rd, first_rd;
    logic        er;
    int          base, n, wp, rp, diff;

    initial begin
        for (int i = 0; i < NB; i++) begin
            ram[i]     = 8'(i * 7 + 3);
            ref_mem[i] = 8'(i * 7 + 3);
        end
        rst_n = 0;
        i_req_valid = 0; i_req_addr = 0; i_rsp_ready = 0;
        d_req_valid = 0; d_req_we = 0; d_req_addr = 0; d_req_wdata = 0; d_rsp_ready = 0;
        repeat (3) @(posedge clk);
        #1;
        // reset values
        chk("rst_mem_address", mem_address, 0);
        chk("rst_mem_rd_en", 32'(mem_read_en), 0);
        chk("rst_mem_wr_en", 32'(mem_write_en), 0);
        chk("rst_mem_wdata", mem_write_data, 0);
        chk("rst_i_rsp_valid", 32'(i_rsp_valid), 0);
        chk("rst_d_rsp_valid", 32'(d_rsp_valid), 0);
        chk("rst_i_rsp_err", 32'(i_rsp_err), 0);
        chk("rst_d_rsp_err", 32'(d_rsp_err), 0);
        chk("rst_i_rsp_rdata", i_rsp_rdata, 0);
        chk("rst_d_rsp_rdata", d_rsp_rdata, 0);
        rst_n = 1;
        @(posedge clk); #1;

        // single D write
        wp = wr_pulses;
        d_txn(1'b1, 32'h10, 32'hDEAD_BEEF, rd, er);
        chk("w10_rdata", rd, 0);
        chk("w10_err", 32'(er), 0);
        chk("w10_wr_pulses", 32'(wr_pulses - wp), 1);
        chk("ram_10", 32'(ram[16]), 32'hEF);
        chk("ram_11", 32'(ram[17]), 32'hBE);
        chk("ram_12", 32'(ram[18]), 32'hAD);
        chk("ram_13", 32'(ram[19]), 32'hDE);

        // I read-back
        rp = rd_pulses;
        i_txn(32'h10, rd, er);
        chk("i10_rdata", rd, 32'hDEAD_BEEF);
        chk("i10_err", 32'(er), 0);
        chk("i10_rd_pulses", 32'(rd_pulses - rp), 1);

        // contention: grants alternate D, I, D, I with 3-cycle spacing
        base = glog.size();
        i_req_valid = 1; i_req_addr = 32'h10; i_rsp_ready = 1;
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h40; d_rsp_ready = 1;
        n = 0;
        while (glog.size() < base + 4 && n < 60) begin @(posedge clk); n++; end
        #1;
        i_req_valid = 0; d_req_valid = 0;
        if (glog.size() < base + 4) chk("cont_timeout", 0, 1);
        else begin
            for (int j = 0; j < 4; j++) chk("cont_order", 32'(glog[base+j]), (j % 2 == 0) ? 32'd1 : 32'd0);
            for (int j = 0; j < 3; j++) chk("cont_spacing", 32'(gcyc[base+j+1] - gcyc[base+j]), 3);
        end
        repeat (4) @(posedge clk);
        #1;

        // out of range
        rp = rd_pulses;
        d_txn(1'b0, 32'd797, 32'h0, rd, er);
        chk("oor797_err", 32'(er), 1);
        chk("oor797_rdata", rd, 0);
        d_txn(1'b0, 32'hFFFF_FFFF, 32'h0, rd, er);
        chk("oorFFFF_err", 32'(er), 1);
        chk("oorFFFF_rdata", rd, 0);
        chk("oor_rd_pulses", 32'(rd_pulses - rp), 0);
        d_txn(1'b0, 32'd796, 32'h0, rd, er);
        chk("a796_err", 32'(er), 0);

        // backpressure on D while I waits
        d_req_valid = 1; d_req_we = 0; d_req_addr = 32'h10; d_rsp_ready = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_req_ready && n < 40);
        @(posedge clk); #1;
        d_req_valid = 0; i_req_valid = 1; i_req_addr = 32'h44; i_rsp_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_rsp_valid && n < 40);
        if (!d_rsp_valid) chk("bp_rsp_timeout", 0, 1);
        first_rd = d_rsp_rdata;
        chk("bp_first_rdata", first_rd, 32'hDEAD_BEEF);
        for (int j = 0; j < 5; j++) begin
            @(negedge clk);
            chk("bp_hold_valid", 32'(d_rsp_valid), 1);
            chk("bp_hold_rdata", d_rsp_rdata, first_rd);
            chk("bp_hold_i_ready", 32'(i_req_ready), 0);
        end
        @(posedge clk); #1;
        d_rsp_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        chk("bp_i_granted", 32'(i_req_ready), 1);
        chk("bp_d_done", 32'(d_rsp_valid), 0);
        @(posedge clk); #1;
        i_req_valid = 0;
        repeat (4) @(posedge clk);
        #1;

        // reset during ACCESS of a write
        d_req_valid = 1; d_req_we = 1; d_req_addr = 32'h20; d_req_wdata = 32'h1234_5678; d_rsp_ready = 1;
        n = 0;
        do begin @(negedge clk); n++; end while (!d_req_ready && n < 40);
        @(posedge clk); #1;
        d_req_valid = 0; rst_n = 0;
        @(posedge clk); #1;
        rst_n = 1;
        @(negedge clk);
        chk("rmid_d_rsp_valid", 32'(d_rsp_valid), 0);
        chk("rmid_i_rsp_valid", 32'(i_rsp_valid), 0);
        chk("rmid_wr_en", 32'(mem_write_en), 0);
        chk("rmid_rd_en", 32'(mem_read_en), 0);
        chk("rmid_ram20", {ram[35], ram[34], ram[33], ram[32]}, 32'h1234_5678);
        @(posedge clk); #1;

        // randomized traffic
        for (int c = 0; c < 3000; c++) begin
            rst_n       = ($urandom_range(0, 499) != 0);
            i_req_valid = ($urandom_range(0, 2) != 0);
            d_req_valid = ($urandom_range(0, 2) != 0);
            d_req_we    = 1'($urandom_range(0, 1));
            i_req_addr  = rnd_addr();
            d_req_addr  = rnd_addr();
            d_req_wdata = $urandom();
            i_rsp_ready = ($urandom_range(0, 3) != 0);
            d_rsp_ready = ($urandom_range(0, 3) != 0);
            @(posedge clk); #1;
        end
        rst_n = 1; i_req_valid = 0; d_req_valid = 0; i_rsp_ready = 1; d_rsp_ready = 1;
        repeat (6) @(posedge clk);
        #1;
        diff = 0;
        for (int i = 0; i < NB; i++) if (ram[i] !== ref_mem[i]) diff++;
        chk("ram_image_diff", 32'(diff), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
